mbist_march_ctrl: RTL and testbench

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_march_ctrl.sv | 133 +++++++++++++
 tb/tb_mbist_march_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C memory BIST controller for a single-port RAM
// whose read data appears one cycle after the address.
// Optional feature: define MBIST_STOP_ON_FAIL_EN to end the test on the
// first miscompare instead of finishing all seven elements.
module mbist_march_ctrl #(
  parameter int                ADDR_W = 6,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] BG0    = 8'h00,
  parameter logic [DATA_W-1:0] BG1    = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_en,
  input  logic [DATA_W-1:0] ram_data_out
);

`ifdef MBIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {IDLE, RD, WR, CMP, DONE} state_t;

  state_t      state;
  logic [2:0]  elem;

  logic              cur_down;
  logic              nxt_down;
  logic [2:0]        nxt_elem;
  logic              at_end;
  logic              read_only;
  logic              miscompare;
  logic              last_cmp;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W-1:0] wr_data;

  // Decode the current march element: direction, terminal address, backgrounds and compare result
  always_comb begin
    cur_down   = (elem == 3'd4) || (elem == 3'd5);
    nxt_elem   = elem + 3'd1;
    nxt_down   = (nxt_elem == 3'd4) || (nxt_elem == 3'd5);
    at_end     = cur_down ? (ram_addr == '0) : (ram_addr == ADDR_MAX);
    read_only  = (elem == 3'd3) || (elem == 3'd6);
    exp_data   = ((elem == 3'd2) || (elem == 3'd5)) ? BG1 : BG0;
    wr_data    = ((elem == 3'd1) || (elem == 3'd4)) ? BG1 : BG0;
    miscompare = (((state == WR) && (elem != 3'd0)) || (state == CMP)) &&
                 (ram_data_out != exp_data);
    last_cmp   = (state == CMP) && (elem == 3'd6) && at_end;
  end

  // March sequencer: state, address walk, RAM strobes and fail capture, all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      elem         <= 3'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      fail_addr    <= '0;
      fail_elem    <= 3'd0;
      ram_addr     <= '0;
      ram_data_in  <= BG0;
      ram_write_en <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if ((state == DONE) && busy) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else if (start) begin
            state        <= WR;
            elem         <= 3'd0;
            busy         <= 1'b1;
            done         <= 1'b0;
            fail         <= 1'b0;
            fail_addr    <= '0;
            fail_elem    <= 3'd0;
            ram_addr     <= '0;
            ram_data_in  <= BG0;
            ram_write_en <= 1'b1;
          end
        end
        RD: begin
          state        <= read_only ? CMP : WR;
          ram_write_en <= !read_only;
          ram_data_in  <= read_only ? BG0 : wr_data;
        end
        WR, CMP: begin
          if (miscompare && !fail) begin
            fail      <= 1'b1;
            fail_addr <= ram_addr;
            fail_elem <= elem;
          end
          if ((STOP_ON_FAIL && miscompare && !fail) || last_cmp) begin
            state        <= DONE;
            ram_write_en <= 1'b0;
            ram_data_in  <= BG0;
          end else if (at_end) begin
            state        <= RD;
            elem         <= nxt_elem;
            ram_addr     <= nxt_down ? ADDR_MAX : '0;
            ram_write_en <= 1'b0;
            ram_data_in  <= BG0;
          end else begin
            ram_addr <= cur_down ? (ram_addr - 1'b1) : (ram_addr + 1'b1);
            if (elem == 3'd0) begin
              state        <= WR;
              ram_write_en <= 1'b1;
              ram_data_in  <= BG0;
            end else begin
              state        <= RD;
              ram_write_en <= 1'b0;
              ram_data_in  <= BG0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: self-checking bench for mbist_march_ctrl with a
// 64x8 RAM model that can hold one stuck-at bit, and a behavioural March C
// reference that predicts outcome, timing and write count.
module tb_mbist_march_ctrl;

`ifdef MBIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       fail;
  logic [5:0] fail_addr;
  logic [2:0] fail_elem;
  logic [5:0] ram_addr;
  logic [7:0] ram_data_in;
  logic       ram_write_en;
  logic [7:0] ram_data_out;

  int tests;
  int failures;

  // March C element table: read background (-1 none), write background (-1 none), direction
  localparam int RD_BG [7] = '{-1, 0, 1, 0, 0, 1, 0};
  localparam int WR_BG [7] = '{ 0, 1, 0, -1, 1, 0, -1};
  localparam bit DN    [7] = '{ 0, 0, 0, 0, 1, 1, 0};

  bit fault_on;
  int fault_addr;
  int fault_bit;
  bit fault_val;

  logic [7:0] mem [64];
  int         wr_count;

  mbist_march_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_addr    (fail_addr),
    .fail_elem    (fail_elem),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_write_en (ram_write_en),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] faulted(input logic [5:0] a, input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (fault_on && (int'(a) == fault_addr)) r[fault_bit] = fault_val;
    return r;
  endfunction

  // Synchronous single-port RAM with the stuck-at bit applied on read
  always @(posedge clk) begin
    if (ram_write_en) begin
      mem[ram_addr] <= ram_data_in;
      wr_count      <= wr_count + 1;
    end
    ram_data_out <= faulted(ram_addr, mem[ram_addr]);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Walk March C over an array: first miscompare, its fail edge, done edge, writes
  task automatic model(input bit fon, input int fa, input int fb, input bit fv,
                       output bit efail, output int eaddr, output int eelem,
                       output int efail_edge, output int edone_edge, output int ewrites);
    logic [7:0] m [64];
    logic [7:0] v;
    logic [7:0] expv;
    int cyc;
    int a;
    bit stopped;
    cyc = 0; efail = 0; eaddr = 0; eelem = 0; efail_edge = -1; ewrites = 0; stopped = 0;
    for (int e = 0; e < 7 && !stopped; e++) begin
      for (int i = 0; i < 64 && !stopped; i++) begin
        a = DN[e] ? 63 - i : i;
        if (RD_BG[e] >= 0) begin
          v = m[a];
          if (fon && a == fa) v[fb] = fv;
          expv = (RD_BG[e] == 1) ? 8'hFF : 8'h00;
          cyc += 1;
          if (v !== expv && !efail) begin
            efail = 1; eaddr = a; eelem = e; efail_edge = cyc + 1;
            if (STOP) stopped = 1;
          end
        end
        if (WR_BG[e] >= 0) begin
          m[a] = (WR_BG[e] == 1) ? 8'hFF : 8'h00;
          ewrites++;
        end
        cyc += 1;
      end
    end
    edone_edge = cyc + 1;
  endtask

  // Pulse start, optionally re-pulse it mid-run, and measure edges until done
  task automatic applyStimulus(input bit fon, input int fa, input int fb, input bit fv, input int restart_at,
                               output int done_edge, output int fail_edge, output bit busy0,
                               output bit clear0, output bit overlap, output int writes);
    int w0;
    fault_on = fon; fault_addr = fa; fault_bit = fb; fault_val = fv;
    @(negedge clk);
    start = 1'b1;
    w0 = wr_count;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy0  = busy;
    clear0 = !(done || fail || (fail_addr != 0) || (fail_elem != 0));
    done_edge = -1; fail_edge = -1; overlap = 0;
    for (int n = 1; n <= 1500; n++) begin
      @(posedge clk);
      #1;
      start = (n == restart_at);
      if (busy && done) overlap = 1;
      if (fail && fail_edge < 0) fail_edge = n;
      if (done) begin
        done_edge = n;
        break;
      end
    end
    start = 1'b0;
    writes = wr_count - w0;
  endtask

  task automatic runMarch(input string name, input bit fon, input int fa, input int fb, input bit fv, input int restart_at);
    bit efail; int eaddr, eelem, efe, ede, ewr;
    int done_edge, fail_edge, writes;
    bit busy0, clear0, overlap;
    model(fon, fa, fb, fv, efail, eaddr, eelem, efe, ede, ewr);
    applyStimulus(fon, fa, fb, fv, restart_at, done_edge, fail_edge, busy0, clear0, overlap, writes);
    checkOutput({name, " done_edge"}, done_edge, ede);
    checkOutput({name, " busy_after_start"}, 32'(busy0), 32'd1);
    checkOutput({name, " cleared_on_start"}, 32'(clear0), 32'd1);
    checkOutput({name, " busy_done_overlap"}, 32'(overlap), 32'd0);
    checkOutput({name, " fail"}, 32'(fail), 32'(efail));
    checkOutput({name, " fail_addr"}, 32'(fail_addr), eaddr);
    checkOutput({name, " fail_elem"}, 32'(fail_elem), eelem);
    checkOutput({name, " fail_edge"}, fail_edge, efe);
    checkOutput({name, " writes"}, writes, ewr);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, " done_held"}, 32'({busy, done}), 32'b01);
  endtask

  initial begin
    int nz;
    int w0;
    tests = 0; failures = 0;
    fault_on = 0; fault_addr = 0; fault_bit = 0; fault_val = 0;
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset fail", 32'(fail), 32'd0);
    checkOutput("reset ram_we", 32'(ram_write_en), 32'd0);
    checkOutput("reset ram_data_in", 32'(ram_data_in), 32'h00);
    checkOutput("reset ram_addr", 32'(ram_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    runMarch("fault_free_restart", 1'b0, 0, 0, 1'b0, 300);
    nz = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 8'h00) nz++;
    checkOutput("fault_free nonzero_words", nz, 0);

    runMarch("sa0_bit0_addr5", 1'b1, 5, 0, 1'b0, 0);
    runMarch("sa1_bit7_addr63", 1'b1, 63, 7, 1'b1, 0);
    for (int k = 0; k < 3; k++)
      runMarch($sformatf("random_fault_%0d", k), 1'b1, int'($urandom_range(0, 63)),
               int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);

    fault_on = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (350) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    w0 = wr_count;
    checkOutput("midrun_reset busy", 32'(busy), 32'd0);
    checkOutput("midrun_reset done", 32'(done), 32'd0);
    checkOutput("midrun_reset fail", 32'({fail, fail_addr, fail_elem}), 32'd0);
    checkOutput("midrun_reset ram_we", 32'(ram_write_en), 32'd0);
    checkOutput("midrun_reset ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("midrun_reset ram_data_in", 32'(ram_data_in), 32'h00);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("after_reset writes", wr_count - w0, 0);
    checkOutput("after_reset idle", 32'({busy, done}), 32'b00);

    runMarch("fault_free_after_reset", 1'b0, 0, 0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
